ysyx_24080006_hpm: RTL

- Parametrised hardware performance-monitor unit for the ysyx_24080006 core; successor to the fixed-function event wires (icache_hit/miss/skip, load/store num/cycle, fetch_cycle, is_compressed).
- Provides mcycle, minstret and NUM_HPM programmable mhpmcounterN with mhpmeventN selectors, mcountinhibit and sticky overflow flags.
- Sits beside the CSR unit, which forwards Zicsr accesses in the 0x320/0xB00/0xB80 ranges here.

---
 rtl/ysyx_24080006_pkg.sv | 41 ++++
 rtl/ysyx_24080006_hpm_counter.sv | 46 ++++
 rtl/ysyx_24080006_hpm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - shared constants, event enum and CSR address helper
//
// Purpose : CSR address constants for the performance-monitor range, the
//           index map of the per-cycle event vector, and the address helper
//           used by the HPM decode.
// Ports   : none (package).

package ysyx_24080006_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MHPMOVF       = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;

  // Bit positions in the events vector; selector value is position + 1.
  typedef enum logic [3:0] {
    EV_ICACHE_HIT  = 4'd0,
    EV_ICACHE_MISS = 4'd1,
    EV_ICACHE_SKIP = 4'd2,
    EV_LOAD        = 4'd3,
    EV_LOAD_CYCLE  = 4'd4,
    EV_STORE       = 4'd5,
    EV_STORE_CYCLE = 4'd6,
    EV_FETCH_CYCLE = 4'd7,
    EV_COMPRESSED  = 4'd8
  } hpm_event_e;

  // Counter index 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
  // Index 1 maps to 0xB02; 0xB01 lies outside this block's address map.
  function automatic logic [11:0] hpm_cnt_addr(input int idx, input logic hi);
    logic [11:0] lo;
    if (idx == 0)      lo = CSR_MCYCLE;
    else if (idx == 1) lo = CSR_MINSTRET;
    else               lo = CSR_MHPMCOUNTER3 + 12'(idx - 2);
    return hi ? (lo + (CSR_MCYCLEH - CSR_MCYCLE)) : lo;
  endfunction

endpackage

// File: rtl/ysyx_24080006_hpm_counter.sv
// rtl/ysyx_24080006_hpm_counter.sv - one performance counter with split low/high write
//
// Purpose : CNT_WIDTH counter that increments on inc unless inhibited; a
//           CSR write to either 32-bit half wins over the increment and
//           freezes the other half for that cycle.
// Ports   : clock, reset (async active-low)
//           inhibit, inc      - increment control
//           wr_lo, wr_hi      - write strobes for bits [31:0] / [W-1:32]
//           wdata             - CSR write data
//           value             - current count
//           wrap              - pulses in the cycle the count rolls over to 0

module ysyx_24080006_hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inhibit,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 wrap
);

  logic bump;

  // A write to either half suppresses the whole increment, so no carry
  // can leak into the half that was not written.
  assign bump = inc & ~inhibit & ~wr_lo & ~wr_hi;
  assign wrap = bump & (&value);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
    end else if (bump) begin
      value <= value + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ysyx_24080006_hpm.sv
// rtl/ysyx_24080006_hpm.sv - hardware performance-monitor unit
//
// Purpose : mcycle, minstret and NUM_HPM programmable event counters with
//           mcountinhibit, per-counter event selectors, sticky overflow
//           flags and an overflow interrupt.
// Ports   : clock, reset (async active-low)
//           instret, events        - increment sources
//           csr_re/we/addr/wdata   - CSR access from the CSR unit
//           csr_rdata, csr_rvalid  - registered read response
//           csr_hit                - address is owned by this block
//           ovf, ovf_irq           - sticky overflow flags and interrupt

module ysyx_24080006_hpm
  import ysyx_24080006_pkg::*;
#(
  parameter int NUM_HPM    = 8,
  parameter int NUM_EVENTS = 16,
  parameter int CNT_WIDTH  = 64,
  parameter int SEL_WIDTH  = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instret,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  csr_re,
  input  logic                  csr_we,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rvalid,
  output logic                  csr_hit,
  output logic [NUM_HPM+1:0]    ovf,
  output logic                  ovf_irq
);

  localparam int NC = NUM_HPM + 2;
  localparam int IW = NUM_HPM + 3;
  // Bit1 of mcountinhibit is the unimplemented time counter.
  localparam logic [IW-1:0]        INH_MASK = ~IW'(2);
  localparam logic [SEL_WIDTH-1:0] SEL_MAX  = SEL_WIDTH'(NUM_EVENTS);

  logic [IW-1:0]        inhibit_q;
  logic [SEL_WIDTH-1:0] sel_q [NUM_HPM];
  logic [NC-1:0]        ovf_en_q;

  logic [NC-1:0]        cnt_inh, cnt_inc, cnt_wr_lo, cnt_wr_hi, cnt_wrap, ovf_clr;
  logic [CNT_WIDTH-1:0] cnt_val [NC];
  logic [NUM_EVENTS:0]  ev_ext;
  logic [NUM_HPM-1:0]   ev_hit, ev_wr;
  logic                 inh_wr, ext_wr;
  logic [31:0]          rd_data;

  // Position 0 is a constant zero so selector k indexes events[k-1] directly.
  assign ev_ext = {events, 1'b0};

  for (genvar i = 0; i < NUM_HPM; i++) begin : g_sel
    assign ev_hit[i] = (sel_q[i] <= SEL_MAX) && ev_ext[sel_q[i]];
  end

  for (genvar c = 0; c < NC; c++) begin : g_cnt
    localparam int INH_BIT = (c == 0) ? 0 : c + 1;
    assign cnt_inh[c] = inhibit_q[INH_BIT];
    if (c == 0) begin : g_cy
      assign cnt_inc[c] = 1'b1;
    end else if (c == 1) begin : g_ir
      assign cnt_inc[c] = instret;
    end else begin : g_hpm
      assign cnt_inc[c] = ev_hit[c-2];
    end

    ysyx_24080006_hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inhibit (cnt_inh[c]),
      .inc     (cnt_inc[c]),
      .wr_lo   (cnt_wr_lo[c]),
      .wr_hi   (cnt_wr_hi[c]),
      .wdata   (csr_wdata),
      .value   (cnt_val[c]),
      .wrap    (cnt_wrap[c])
    );
  end

  // Address decode, read mux and write strobes.
  always_comb begin
    csr_hit   = 1'b0;
    rd_data   = '0;
    cnt_wr_lo = '0;
    cnt_wr_hi = '0;
    ev_wr     = '0;
    inh_wr    = 1'b0;
    ext_wr    = 1'b0;
    ovf_clr   = '0;

    if (csr_addr == CSR_MCOUNTINHIBIT) begin
      csr_hit = 1'b1;
      rd_data = 32'(inhibit_q);
      inh_wr  = csr_we;
    end

    if (csr_addr == CSR_MHPMOVF) begin
      csr_hit    = 1'b1;
      rd_data    = {22'b0, ovf[1:0], 6'b0, ovf_en_q[1:0]};
      ext_wr     = csr_we;
      ovf_clr[0] = csr_we & csr_wdata[8];
      ovf_clr[1] = csr_we & csr_wdata[9];
    end

    for (int c = 0; c < NC; c++) begin
      if (csr_addr == hpm_cnt_addr(c, 1'b0)) begin
        csr_hit      = 1'b1;
        rd_data      = cnt_val[c][31:0];
        cnt_wr_lo[c] = csr_we;
      end
      if (csr_addr == hpm_cnt_addr(c, 1'b1)) begin
        csr_hit      = 1'b1;
        rd_data      = 32'(cnt_val[c] >> 32);
        cnt_wr_hi[c] = csr_we;
      end
    end

    for (int i = 0; i < NUM_HPM; i++) begin
      if (csr_addr == CSR_MHPMEVENT3 + 12'(i)) begin
        csr_hit        = 1'b1;
        rd_data        = 32'(sel_q[i]);
        rd_data[31]    = ovf_en_q[2+i];
        rd_data[30]    = ovf[2+i];
        ev_wr[i]       = csr_we;
        ovf_clr[2+i]   = csr_we & csr_wdata[30];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inhibit_q  <= '0;
      ovf_en_q   <= '0;
      ovf        <= '0;
      ovf_irq    <= 1'b0;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      for (int i = 0; i < NUM_HPM; i++) sel_q[i] <= '0;
    end else begin
      if (inh_wr) inhibit_q <= csr_wdata[IW-1:0] & INH_MASK;
      if (ext_wr) ovf_en_q[1:0] <= csr_wdata[1:0];
      for (int i = 0; i < NUM_HPM; i++) begin
        if (ev_wr[i]) begin
          // Out-of-range selectors are stored as "no event".
          sel_q[i]       <= (csr_wdata[SEL_WIDTH-1:0] > SEL_MAX) ? '0 : csr_wdata[SEL_WIDTH-1:0];
          ovf_en_q[2+i]  <= csr_wdata[31];
        end
      end
      // A wrap in the same cycle as a clear keeps the flag set.
      ovf        <= (ovf & ~ovf_clr) | cnt_wrap;
      ovf_irq    <= |(ovf & ovf_en_q);
      csr_rvalid <= csr_re;
      if (csr_re) csr_rdata <= rd_data;
    end
  end

endmodule
